bram_pipe: RTL and testbench

Parametrised successor to the team's byte-strobed block RAM. It adds three things:
- a configurable column width;
- an optional extra output pipeline stage;
- a valid/ready read interface with a response buffer, so consumer backpressure never drops read data.

The write port is fire-and-forget. The block serves as instruction/data memory and frame buffer behind bus slaves in the SoC.

---
 rtl/bram_pipe.sv | 133 +++++++++++++
 tb/tb_bram_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_pipe.sv
// bram_pipe: byte-strobed block RAM with a pipelined valid/ready read port and a credit-guarded response FIFO
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset of control state (memory is never reset)
//   wstrb, waddr, wdata             fire-and-forget write port, per-column strobes
//   rd_req_valid/ready, rd_addr     read request handshake
//   rd_resp_valid/ready, rd_data    read response handshake (first-word-fall-through)
// Optional feature: define BRAM_BYPASS_EN for write-first collision behaviour (default is read-first).
module bram_pipe #(
  parameter string INIT    = "",
  parameter int    SIZE    = 1024,
  parameter int    COLS    = 4,
  parameter int    COL_W   = 8,
  parameter int    OUT_REG = 0,
  parameter int    AW      = $clog2(SIZE),
  parameter int    DW      = COLS * COL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] wstrb,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            rd_req_valid,
  output logic            rd_req_ready,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_resp_valid,
  input  logic            rd_resp_ready,
  output logic [DW-1:0]   rd_data
);
  localparam int L  = 1 + OUT_REG;
  localparam int D  = L + 1;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [CW:0] DLIM = D;

  logic [DW-1:0] mem [SIZE];

  always_ff @(posedge clk)
    for (int i = 0; i < COLS; i++)
      if (wstrb[i]) mem[waddr][i*COL_W +: COL_W] <= wdata[i*COL_W +: COL_W];

  logic          accept;
  logic [DW-1:0] s1_q, s1_data, out_d;
  logic          v1_q, out_v;

  assign accept = rd_req_valid && rd_req_ready;

  always_ff @(posedge clk)
    if (accept) s1_q <= mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v1_q <= 1'b0;
    else v1_q <= accept;

`ifdef BRAM_BYPASS_EN
  // Address match is folded into the registered strobes: a zero mask means no collision.
  logic [COLS-1:0] byp_q;
  logic [DW-1:0]   bwd_q;
  always_ff @(posedge clk)
    if (accept) begin
      byp_q <= (waddr == rd_addr) ? wstrb : '0;
      bwd_q <= wdata;
    end
  always_comb begin
    s1_data = s1_q;
    for (int i = 0; i < COLS; i++)
      if (byp_q[i]) s1_data[i*COL_W +: COL_W] = bwd_q[i*COL_W +: COL_W];
  end
`else
  assign s1_data = s1_q;
`endif

  if (OUT_REG != 0) begin : g_out
    logic [DW-1:0] s2_q;
    logic          v2_q;
    always_ff @(posedge clk)
      if (v1_q) s2_q <= s1_data;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v2_q <= 1'b0;
      else v2_q <= v1_q;
    assign out_v = v2_q;
    assign out_d = s2_q;
  end else begin : g_noout
    assign out_v = v1_q;
    assign out_d = s1_data;
  end

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DW-1:0] fifo_q [D];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d, inflight_q, inflight_d;
  logic [DW-1:0] last_q, last_d, head;
  logic          empty, pop, push, deq;

  // An empty FIFO passes the pipeline output straight through, so a response
  // consumed on arrival never occupies an entry.
  assign empty         = cnt_q == '0;
  assign head          = empty ? out_d : fifo_q[rptr_q];
  assign rd_resp_valid = !empty || out_v;
  assign pop           = rd_resp_valid && rd_resp_ready;
  assign push          = out_v && !(empty && pop);
  assign deq           = pop && !empty;
  assign rd_data       = rd_resp_valid ? head : last_q;
  assign rd_req_ready  = ({1'b0, inflight_q} + {1'b0, cnt_q}) < DLIM;

  always_comb begin
    wptr_d     = push ? inc(wptr_q) : wptr_q;
    rptr_d     = deq ? inc(rptr_q) : rptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(deq);
    inflight_d = inflight_q + CW'(accept) - CW'(out_v);
    last_d     = pop ? head : last_q;
  end

  always_ff @(posedge clk)
    if (push) fifo_q[wptr_q] <= out_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
      last_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
    end
endmodule

// File: tb/tb_bram_pipe.sv
// tb_bram_pipe: directed, table-driven bench for bram_pipe with OUT_REG=0 (u0) and OUT_REG=1 (u1) side by side
module tb_bram_pipe;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [3:0]  wstrb = '0;
  logic [9:0]  waddr = '0, rd_addr = '0;
  logic [31:0] wdata = '0;
  logic        rd_req_valid = 1'b0, rd_resp_ready = 1'b0;
  logic [1:0]  rdy, rv;
  logic [1:0][31:0] rdat;
  int checks = 0, fails = 0;
  int pops[2] = '{0, 0};
  int acc[2] = '{0, 0};
  logic [31:0] model [1024];
  logic [31:0] sbq [2][$];
  logic [31:0] sb_e;

  always #5 clk = ~clk;

  bram_pipe #(.OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rdy[0]), .rd_addr(rd_addr),
    .rd_resp_valid(rv[0]), .rd_resp_ready(rd_resp_ready), .rd_data(rdat[0]));

  bram_pipe #(.OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rdy[1]), .rd_addr(rd_addr),
    .rd_resp_valid(rv[1]), .rd_resp_ready(rd_resp_ready), .rd_data(rdat[1]));

  typedef struct {
    bit          same;
    logic [9:0]  wa;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [31:0] ex;
  } vec_t;

`ifdef BRAM_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h0000FFFF;
`else
  localparam logic [31:0] COLL_EXP = 32'h00000000;
`endif

  vec_t tbl[9];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] ex);
    checks++;
    if (got !== ex) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", n, got, ex);
    end
  endtask

  // Write (optionally in the same cycle as the read), read, then check latency and data on both DUTs.
  task automatic do_vec(input vec_t v, input int idx);
    @(posedge clk) #1;
    wstrb = v.ws; waddr = v.wa; wdata = v.wd;
    if (v.same) begin
      rd_req_valid = 1'b1; rd_addr = v.ra;
    end else begin
      @(posedge clk) #1;
      wstrb = '0; rd_req_valid = 1'b1; rd_addr = v.ra;
    end
    @(posedge clk) #1;
    wstrb = '0; rd_req_valid = 1'b0;
    chk($sformatf("v%0d_u0_valid", idx), 32'(rv[0]), 32'd1);
    chk($sformatf("v%0d_u0_data", idx), rdat[0], v.ex);
    chk($sformatf("v%0d_u1_not_yet", idx), 32'(rv[1]), 32'd0);
    @(posedge clk) #1;
    chk($sformatf("v%0d_u1_valid", idx), 32'(rv[1]), 32'd1);
    chk($sformatf("v%0d_u1_data", idx), rdat[1], v.ex);
    chk($sformatf("v%0d_u0_popped", idx), 32'(rv[0]), 32'd0);
    chk($sformatf("v%0d_u0_hold", idx), rdat[0], v.ex);
  endtask

  initial begin
    int b0, b1;
    tbl[0] = '{1'b0, 10'd5,    4'hF,    32'hDEADBEEF, 10'd5,    32'hDEADBEEF};
    tbl[1] = '{1'b0, 10'd7,    4'hF,    32'h11223344, 10'd7,    32'h11223344};
    tbl[2] = '{1'b0, 10'd7,    4'b0101, 32'hAABBCCDD, 10'd7,    32'h11BB33DD};
    tbl[3] = '{1'b0, 10'd3,    4'hF,    32'h00000000, 10'd3,    32'h00000000};
    tbl[4] = '{1'b1, 10'd3,    4'b0011, 32'hFFFFFFFF, 10'd3,    COLL_EXP};
    tbl[5] = '{1'b0, 10'd3,    4'h0,    32'h12345678, 10'd3,    32'h0000FFFF};
    tbl[6] = '{1'b0, 10'd1023, 4'hF,    32'h0BADF00D, 10'd1023, 32'h0BADF00D};
    tbl[7] = '{1'b0, 10'd0,    4'hF,    32'h12345678, 10'd0,    32'h12345678};
    tbl[8] = '{1'b0, 10'd0,    4'b0010, 32'h0000AB00, 10'd0,    32'h1234AB78};

    // Scoreboard: sampled on the falling edge, mirrors what the next rising edge does.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sbq[0].delete();
          sbq[1].delete();
        end else begin
          sb_e = model[rd_addr];
`ifdef BRAM_BYPASS_EN
          if (waddr == rd_addr)
            for (int c = 0; c < 4; c++)
              if (wstrb[c]) sb_e[c*8 +: 8] = wdata[c*8 +: 8];
`endif
          for (int k = 0; k < 2; k++) begin
            if (rv[k] && rd_resp_ready) begin
              pops[k]++;
              checks++;
              if (sbq[k].size() == 0) begin
                fails++;
                $display("FAIL sb_extra_u%0d got=%h expected=none", k, rdat[k]);
              end else if (rdat[k] !== sbq[k][0]) begin
                fails++;
                $display("FAIL sb_order_u%0d got=%h expected=%h", k, rdat[k], sbq[k][0]);
                void'(sbq[k].pop_front());
              end else void'(sbq[k].pop_front());
            end
            if (rd_req_valid && rdy[k]) begin
              sbq[k].push_back(sb_e);
              acc[k]++;
            end
          end
        end
        for (int c = 0; c < 4; c++)
          if (wstrb[c]) model[waddr][c*8 +: 8] = wdata[c*8 +: 8];
      end
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rv), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd3);
    chk("rst_data_u0", rdat[0], 32'd0);
    chk("rst_data_u1", rdat[1], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rd_resp_ready = 1'b1;

    // Back-to-back reads 0..15
    for (int i = 0; i < 16; i++) begin
      @(posedge clk) #1;
      wstrb = 4'hF; waddr = 10'(i); wdata = 32'hC0DE0000 + 32'(i * 257);
    end
    @(posedge clk) #1;
    wstrb = '0;
    b0 = pops[0]; b1 = pops[1];
    for (int i = 0; i < 16; i++) begin
      rd_req_valid = 1'b1; rd_addr = 10'(i);
      chk($sformatf("b2b_ready_%0d", i), 32'(rdy), 32'd3);
      @(posedge clk) #1;
    end
    rd_req_valid = 1'b0;
    @(posedge clk) #1;
    chk("b2b_u0_count", 32'(pops[0] - b0), 32'd16);
    chk("b2b_u1_count_lag", 32'(pops[1] - b1), 32'd15);
    @(posedge clk) #1;
    chk("b2b_u1_count", 32'(pops[1] - b1), 32'd16);

    // Backpressure: exactly D accepted, then all D delivered
    rd_resp_ready = 1'b0;
    b0 = acc[0]; b1 = acc[1];
    for (int i = 0; i < 8; i++) begin
      rd_req_valid = 1'b1; rd_addr = 10'(i);
      @(posedge clk) #1;
    end
    chk("bp_u0_accepted", 32'(acc[0] - b0), 32'd2);
    chk("bp_u1_accepted", 32'(acc[1] - b1), 32'd3);
    chk("bp_ready_low", 32'(rdy), 32'd0);
    chk("bp_valid_high", 32'(rv), 32'd3);
    rd_req_valid = 1'b0; rd_resp_ready = 1'b1;
    b0 = pops[0]; b1 = pops[1];
    repeat (6) @(posedge clk);
    #1;
    chk("bp_u0_delivered", 32'(pops[0] - b0), 32'd2);
    chk("bp_u1_delivered", 32'(pops[1] - b1), 32'd3);
    chk("bp_drained", 32'(rv), 32'd0);
    chk("bp_ready_back", 32'(rdy), 32'd3);

    // Directed write/read vectors
    for (int i = 0; i < 9; i++) do_vec(tbl[i], i);
    repeat (2) @(posedge clk);

    // Reset mid-operation
    #1 rd_resp_ready = 1'b0; rd_req_valid = 1'b1; rd_addr = 10'd5;
    @(posedge clk) #1 rd_addr = 10'd7;
    @(posedge clk) #1 rd_req_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rv), 32'd0);
    chk("mid_rst_ready", 32'(rdy), 32'd3);
    chk("mid_rst_data", rdat[0] | rdat[1], 32'd0);
    @(posedge clk) #1 rst_n = 1'b1; rd_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      chk($sformatf("post_rst_valid_%0d", i), 32'(rv), 32'd0);
      chk($sformatf("post_rst_ready_%0d", i), 32'(rdy), 32'd3);
    end
    do_vec('{1'b0, 10'd5, 4'h0, 32'h0, 10'd5, 32'hDEADBEEF}, 9);

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_u0_empty", 32'(sbq[0].size()), 32'd0);
    chk("final_sb_u1_empty", 32'(sbq[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
